// File: rtl/mips_mem_pkg.sv
// Shared definitions for the store-side memory path: entry layout, byte-enable
// width, word-address slice position and a byte-lane mask helper.
package mips_mem_pkg;

  localparam int WB_AW    = 32;
  localparam int WB_DW    = 32;
  localparam int BYTEEN_W = WB_DW / 8;
  // Word granularity: address bits below WORD_LSB select a byte within a word.
  localparam int WORD_LSB = 2;

  typedef struct packed {
    logic [WB_AW-1:0]    addr;
    logic [WB_DW-1:0]    data;
    logic [BYTEEN_W-1:0] byteen;
    logic                valid;
  } wbuf_entry_t;

  // Expand byte enables into a bit mask covering the enabled data lanes.
  function automatic logic [WB_DW-1:0] lane_mask(input logic [BYTEEN_W-1:0] be);
    logic [WB_DW-1:0] m;
    m = '0;
    for (int i = 0; i < BYTEEN_W; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wbuf_match.sv
// Per-entry word-address comparator vector: bit i is set when entry i is valid
// and its word address equals the key word address.
module wbuf_match
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WW    = WB_AW - WORD_LSB
) (
  input  logic [DEPTH-1:0][WW-1:0] entry_word,
  input  logic [DEPTH-1:0]         entry_valid,
  input  logic [WW-1:0]            key_word,
  output logic [DEPTH-1:0]         match
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match[gi] = entry_valid[gi] && (entry_word[gi] == key_word);
    end
  endgenerate

endmodule

// File: rtl/write_buffer.sv
// Posted store buffer between the data cache and the memory interface.
// Stores are queued in a DEPTH-entry FIFO and drained in strict order with a
// req/ack handshake; loads that hit any pending store word raise rd_hit.
// Optional feature macro WBUF_MERGE_EN: stores to the newest entry's word
// merge into it (when that entry is not the head under issue).
module write_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_valid,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_byteen,
  output logic            wr_ready,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_hit,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_data,
  output logic [DW/8-1:0] mem_byteen,
  input  logic            mem_ack,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = AW - WORD_LSB;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wbuf_entry_t entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic [DEPTH-1:0][WW-1:0] entry_word;
  logic [DEPTH-1:0]         entry_valid;
  logic [DEPTH-1:0]         rd_match;
  logic                     merge_hit;
  logic                     push;
  logic                     pop;
  logic                     unused_rd_low;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_view
      assign entry_word[gi]  = entries[gi].addr[AW-1:WORD_LSB];
      assign entry_valid[gi] = entries[gi].valid;
    end
  endgenerate

  // Byte offset of a load never affects the word match.
  assign unused_rd_low = ^rd_addr[WORD_LSB-1:0];

  wbuf_match #(.DEPTH(DEPTH), .WW(WW)) u_rd_match (
    .entry_word  (entry_word),
    .entry_valid (entry_valid),
    .key_word    (rd_addr[AW-1:WORD_LSB]),
    .match       (rd_match)
  );

`ifdef WBUF_MERGE_EN
  logic [DEPTH-1:0] wr_match;
  logic [PW-1:0]    newest;

  wbuf_match #(.DEPTH(DEPTH), .WW(WW)) u_wr_match (
    .entry_word  (entry_word),
    .entry_valid (entry_valid),
    .key_word    (wr_addr[AW-1:WORD_LSB]),
    .match       (wr_match)
  );

  assign newest = tail - PW'(1);
  // With two or more entries the newest one can never be the head under issue.
  assign merge_hit = wr_valid && (count > (PW+1)'(1)) && wr_match[newest];
`else
  assign merge_hit = 1'b0;
`endif

  // Full refuses new allocations regardless of a same-cycle ack.
  assign wr_ready   = (count != FULL_CNT) || merge_hit;
  assign push       = wr_valid && wr_ready && !merge_hit;
  assign mem_req    = (count != '0);
  assign pop        = mem_ack && mem_req;
  assign empty      = (count == '0);
  assign rd_hit     = |rd_match;
  assign mem_addr   = entries[head].addr;
  assign mem_data   = entries[head].data;
  assign mem_byteen = entries[head].byteen;

  // Pointer, occupancy and entry storage updates; reset drops all pending stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (push) begin
        entries[tail] <= '{addr: wr_addr, data: wr_data, byteen: wr_byteen, valid: 1'b1};
        tail          <= tail + PW'(1);
      end
`ifdef WBUF_MERGE_EN
      if (merge_hit) begin
        entries[newest].data   <= (entries[newest].data & ~lane_mask(wr_byteen)) |
                                  (wr_data & lane_mask(wr_byteen));
        entries[newest].byteen <= entries[newest].byteen | wr_byteen;
      end
`endif
      // Push and pop never target the same slot: push needs count<DEPTH, pop count>0
      // with head != tail unless full.
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: hand-derived vector table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
// Build with WBUF_MERGE_EN defined to check the merging variant.
`timescale 1ns/1ps
module tb_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef WBUF_MERGE_EN
  localparam bit MERGE_ON = 1'b1;
`else
  localparam bit MERGE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_byteen;
  logic          wr_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_hit;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [3:0]    mem_byteen;
  logic          mem_ack;
  logic          empty;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_byteen  (wr_byteen),
    .wr_ready   (wr_ready),
    .rd_addr    (rd_addr),
    .rd_hit     (rd_hit),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_byteen (mem_byteen),
    .mem_ack    (mem_ack),
    .empty      (empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic        wv;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  wb;
    logic        ack;
    logic [31:0] ra;
    logic        e_req;
    logic        e_ready;
    logic        e_hit;
    logic        e_empty;
    logic        chk_bus;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  wr_t  model_q[$];
  wr_t  drain_log[$];
  vec_t vt[12];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Any pending store covering the load's word.
  function automatic logic model_hit(input logic [31:0] ra);
    foreach (model_q[i]) begin
      if (model_q[i].addr[31:2] == ra[31:2]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // A store merges into the newest entry when that entry is not the head.
  function automatic logic model_merge(input logic wv, input logic [31:0] wa);
    if (!MERGE_ON || !wv || model_q.size() < 2) return 1'b0;
    return model_q[model_q.size()-1].addr[31:2] == wa[31:2];
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, advance.
  task automatic step(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] wb, input logic ack, input logic [31:0] ra);
    logic exp_ready;
    logic mrg;
    logic pop_ok;
    wr_t  e;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    wr_byteen = wb;
    mem_ack   = ack;
    rd_addr   = ra;
    #1;
    mrg       = model_merge(wv, wa);
    exp_ready = (model_q.size() < DEPTH) || mrg;
    pop_ok    = ack && (model_q.size() != 0);
    chk("mem_req", {31'd0, mem_req}, {31'd0, model_q.size() != 0});
    chk("empty", {31'd0, empty}, {31'd0, model_q.size() == 0});
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready});
    chk("rd_hit", {31'd0, rd_hit}, {31'd0, model_hit(ra)});
    if (model_q.size() != 0) begin
      chk("mem_addr", mem_addr, model_q[0].addr);
      chk("mem_data", mem_data, model_q[0].data);
      chk("mem_byteen", {28'd0, mem_byteen}, {28'd0, model_q[0].be});
    end
    if (ack && mem_req) begin
      drain_log.push_back('{mem_addr, mem_data, mem_byteen});
      $display("MEMWR addr=%h data=%h be=%h", mem_addr, mem_data, mem_byteen);
    end
    if (wv && exp_ready && mrg) begin
      e = model_q[model_q.size()-1];
      for (int i = 0; i < 4; i++) begin
        if (wb[i]) e.data[i*8 +: 8] = wd[i*8 +: 8];
      end
      e.be = e.be | wb;
      model_q[model_q.size()-1] = e;
    end
    if (pop_ok) void'(model_q.pop_front());
    if (wv && exp_ready && !mrg) model_q.push_back('{wa, wd, wb});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 32'h0, 32'h0, 4'h0, ack, 32'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && model_q.size() != 0; k++) idle(1'b1);
    chk("drain_done", model_q.size(), 32'd0);
  endtask

  initial begin
    int issued;
    int dsz;
    // addr/data, store side ................ load   expected before edge
    vt[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,   32'h0};
    vt[1]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 32'h106, 32'h00CC0000, 4'h4, 1'b0, 32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0};
    vt[4]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h106, 32'h00CC0000};
    vt[5]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h104, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h106, 32'h00CC0000};
    vt[6]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0};
    vt[7]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0};
    vt[8]  = '{1'b1, 32'h10,  32'h1,        4'hF, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0};
    vt[9]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h10,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10,  32'h1};
    vt[10] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h10,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10,  32'h1};
    vt[11] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h10,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0};

    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_byteen = '0;
    mem_ack   = 1'b0;
    rd_addr   = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    // Reset state; rd_addr 0 matches the zeroed entries' addresses, so rd_hit=0
    // also shows that invalid entries never match.
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_rd_hit", {31'd0, rd_hit}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_mem_byteen", {28'd0, mem_byteen}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Vector table: single store latency/drain, load hit on partial word, ignored ack.
    for (int i = 0; i < 12; i++) begin
      wr_valid  = vt[i].wv;
      wr_addr   = vt[i].wa;
      wr_data   = vt[i].wd;
      wr_byteen = vt[i].wb;
      mem_ack   = vt[i].ack;
      rd_addr   = vt[i].ra;
      #1;
      chk($sformatf("vec%0d_req", i), {31'd0, mem_req}, {31'd0, vt[i].e_req});
      chk($sformatf("vec%0d_ready", i), {31'd0, wr_ready}, {31'd0, vt[i].e_ready});
      chk($sformatf("vec%0d_hit", i), {31'd0, rd_hit}, {31'd0, vt[i].e_hit});
      chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vt[i].e_empty});
      if (vt[i].chk_bus) begin
        chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
        chk($sformatf("vec%0d_data", i), mem_data, vt[i].e_data);
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Reset mid-drain with three pending entries.
    step(1'b1, 32'h400, 32'hA, 4'hF, 1'b0, 32'h0);
    step(1'b1, 32'h404, 32'hB, 4'hF, 1'b0, 32'h0);
    step(1'b1, 32'h408, 32'hC, 4'hF, 1'b0, 32'h0);
    mem_ack  = 1'b1;
    wr_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    model_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle(1'b1);
    step(1'b1, 32'h40C, 32'hD, 4'hF, 1'b0, 32'h40C);
    idle(1'b0);
    drain();

    // Full buffer: 5th store refused, even alongside an ack, then accepted.
    drain_log.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h500 + 32'(i*4), 32'(i+1), 4'hF, 1'b0, 32'h0);
    step(1'b1, 32'h510, 32'd5, 4'hF, 1'b0, 32'h0);
    step(1'b1, 32'h510, 32'd5, 4'hF, 1'b1, 32'h0);
    step(1'b1, 32'h510, 32'd5, 4'hF, 1'b0, 32'h0);
    drain();
    chk("full_order_cnt", drain_log.size(), 32'd5);
    dsz = drain_log.size();
    for (int i = 0; i < 5 && i < dsz; i++) chk($sformatf("full_order_%0d", i), drain_log[i].data, 32'(i+1));

    // Store merge into the newest entry (or three separate writes).
    drain_log.delete();
    step(1'b1, 32'h200, 32'h11,   4'h1, 1'b0, 32'h0);
    step(1'b1, 32'h300, 32'hAA,   4'h1, 1'b0, 32'h0);
    step(1'b1, 32'h300, 32'hBB00, 4'h2, 1'b0, 32'h0);
    drain();
    dsz = drain_log.size();
`ifdef WBUF_MERGE_EN
    chk("merge_cnt", dsz, 32'd2);
    if (dsz == 2) begin
      chk("merge_w0_addr", drain_log[0].addr, 32'h200);
      chk("merge_w1_addr", drain_log[1].addr, 32'h300);
      chk("merge_w1_data", drain_log[1].data, 32'hBBAA);
      chk("merge_w1_be", {28'd0, drain_log[1].be}, 32'h3);
    end
`else
    chk("merge_cnt", dsz, 32'd3);
    if (dsz == 3) begin
      chk("nomerge_w1_data", drain_log[1].data, 32'hAA);
      chk("nomerge_w2_data", drain_log[2].data, 32'hBB00);
      chk("nomerge_w2_be", {28'd0, drain_log[2].be}, 32'h2);
    end
`endif

    // Pointer wrap: 10 stores with random ack gaps.
    drain_log.delete();
    issued = 0;
    for (int k = 0; k < 300 && (issued < 10 || model_q.size() != 0); k++) begin
      if (issued < 10) begin
        if (model_q.size() < DEPTH) begin
          step(1'b1, 32'h1000 + 32'(issued*4), 32'h600 + 32'(issued), 4'hF,
               1'($urandom_range(0, 2) == 0), 32'h1000);
          issued++;
        end else begin
          step(1'b1, 32'h1000 + 32'(issued*4), 32'h600 + 32'(issued), 4'hF,
               1'($urandom_range(0, 2) == 0), 32'h1000);
        end
      end else begin
        idle(1'($urandom_range(0, 1)));
      end
    end
    chk("wrap_cnt", drain_log.size(), 32'd10);
    dsz = drain_log.size();
    for (int i = 0; i < 10 && i < dsz; i++) chk($sformatf("wrap_order_%0d", i), drain_log[i].data, 32'h600 + 32'(i));

    // Randomized traffic over a small word pool to exercise hits and merges.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 1)),
           32'h2000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
           $urandom, 4'($urandom_range(1, 15)),
           1'($urandom_range(0, 2) != 0),
           32'h2000 + 32'($urandom_range(0, 4) * 4));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
